// File: rtl/trap_ctrl_pkg.sv
// Shared machine-mode CSR definitions: CSR addresses (common with csrrf),
// exception cause codes and mstatus bit positions.
package trap_ctrl_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS = 12'h300,
    CSR_MTVEC   = 12'h305,
    CSR_MEPC    = 12'h341,
    CSR_MCAUSE  = 12'h342,
    CSR_MTVAL   = 12'h343
  } csr_addr_e;

  typedef enum logic [3:0] {
    CAUSE_INSTR_MISALIGN = 4'd0,
    CAUSE_ILLEGAL        = 4'd2,
    CAUSE_BREAKPOINT     = 4'd3,
    CAUSE_LD_MISALIGN    = 4'd4,
    CAUSE_ST_MISALIGN    = 4'd6,
    CAUSE_ECALL_M        = 4'd11
  } exc_cause_e;

  // mcause value for the machine external interrupt (interrupt bit set, code 11)
  localparam logic [31:0] MCAUSE_IRQ_EXT = 32'h8000_000B;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;
  localparam logic [1:0] PRIV_M   = 2'b11;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap/MRET sequencer: captures a commit-stage event, writes the
// trap CSRs one per cycle, then redirects fetch to mtvec or mepc.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetb,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_tval,
  input  logic [31:0] pc_in,
  input  logic        mret_valid,
  input  logic        irq_ext,
  input  logic        mie_meie,
  input  logic [31:0] mstatus_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        csr_we,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    IDLE,
    SAVE_EPC,
    SAVE_CAUSE,
    SAVE_TVAL,
    SAVE_STATUS,
    MRET_STATUS,
    REDIRECT
  } state_t;

  state_t      state;
  logic [31:0] lat_pc;
  logic [3:0]  lat_cause;
  logic [31:0] lat_tval;
  logic [31:0] lat_mstatus;
  logic        lat_irq;
  logic        lat_mret;

  logic irq_pend;
  assign irq_pend = irq_ext & mie_meie & mstatus_in[MSTATUS_MIE_BIT];

  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
    logic [31:0] w;
    w = ms;
    w[MSTATUS_MPIE_BIT]              = ms[MSTATUS_MIE_BIT];
    w[MSTATUS_MIE_BIT]               = 1'b0;
    w[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
    return w;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
    logic [31:0] w;
    w = ms;
    w[MSTATUS_MIE_BIT]               = ms[MSTATUS_MPIE_BIT];
    w[MSTATUS_MPIE_BIT]              = 1'b1;
    w[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
    return w;
  endfunction

  // Outputs are registered from the current state, so they trail the state
  // by one cycle: acceptance at T shows the first CSR write at T+1.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state          <= IDLE;
      lat_pc         <= '0;
      lat_cause      <= '0;
      lat_tval       <= '0;
      lat_mstatus    <= '0;
      lat_irq        <= 1'b0;
      lat_mret       <= 1'b0;
      csr_we         <= 1'b0;
      csr_addr       <= '0;
      csr_wdata      <= '0;
      stall          <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      csr_we         <= 1'b0;
      csr_addr       <= '0;
      csr_wdata      <= '0;
      stall          <= (state != IDLE);
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;

      unique case (state)
        IDLE: begin
          // A faulting MRET raises exc_valid too, so exceptions win over it.
          if (exc_valid) begin
            lat_pc      <= pc_in;
            lat_cause   <= exc_cause;
            lat_tval    <= exc_tval;
            lat_mstatus <= mstatus_in;
            lat_irq     <= 1'b0;
            lat_mret    <= 1'b0;
            state       <= SAVE_EPC;
          end else if (irq_pend) begin
            lat_pc      <= pc_in;
            lat_cause   <= '0;
            lat_tval    <= '0;
            lat_mstatus <= mstatus_in;
            lat_irq     <= 1'b1;
            lat_mret    <= 1'b0;
            state       <= SAVE_EPC;
          end else if (mret_valid) begin
            lat_mstatus <= mstatus_in;
            lat_irq     <= 1'b0;
            lat_mret    <= 1'b1;
            state       <= MRET_STATUS;
          end
        end
        SAVE_EPC: begin
          csr_we    <= 1'b1;
          csr_addr  <= CSR_MEPC;
          csr_wdata <= lat_pc & WORD_ALIGN_MASK;
          flush     <= 1'b1;
          state     <= SAVE_CAUSE;
        end
        SAVE_CAUSE: begin
          csr_we    <= 1'b1;
          csr_addr  <= CSR_MCAUSE;
          csr_wdata <= lat_irq ? MCAUSE_IRQ_EXT : {28'b0, lat_cause};
          state     <= SAVE_TVAL;
        end
        SAVE_TVAL: begin
          csr_we    <= 1'b1;
          csr_addr  <= CSR_MTVAL;
          csr_wdata <= lat_tval;
          state     <= SAVE_STATUS;
        end
        SAVE_STATUS: begin
          csr_we    <= 1'b1;
          csr_addr  <= CSR_MSTATUS;
          csr_wdata <= trap_mstatus(lat_mstatus);
          state     <= REDIRECT;
        end
        MRET_STATUS: begin
          csr_we    <= 1'b1;
          csr_addr  <= CSR_MSTATUS;
          csr_wdata <= mret_mstatus(lat_mstatus);
          flush     <= 1'b1;
          state     <= REDIRECT;
        end
        REDIRECT: begin
          // Target is read live here so the just-written CSR values are seen.
          redirect_valid <= 1'b1;
          redirect_pc    <= lat_mret ? (mepc_in & WORD_ALIGN_MASK)
                                     : (mtvec_in & WORD_ALIGN_MASK);
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized
// back-to-back events checked against a write-list reference model.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetb;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_tval;
  logic [31:0] pc_in;
  logic        mret_valid;
  logic        irq_ext;
  logic        mie_meie;
  logic [31:0] mstatus_in;
  logic [31:0] mtvec_in;
  logic [31:0] mepc_in;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  trap_ctrl dut (
    .clk(clk), .resetb(resetb),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval),
    .pc_in(pc_in), .mret_valid(mret_valid), .irq_ext(irq_ext),
    .mie_meie(mie_meie), .mstatus_in(mstatus_in), .mtvec_in(mtvec_in),
    .mepc_in(mepc_in), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag, input out_t e);
    chk({tag, ".we"},    {31'b0, csr_we},         {31'b0, e.we});
    chk({tag, ".addr"},  {20'b0, csr_addr},       {20'b0, e.addr});
    chk({tag, ".wdata"}, csr_wdata,               e.wdata);
    chk({tag, ".stall"}, {31'b0, stall},          {31'b0, e.stall});
    chk({tag, ".flush"}, {31'b0, flush},          {31'b0, e.flush});
    chk({tag, ".rv"},    {31'b0, redirect_valid}, {31'b0, e.rv});
    if (e.rv) chk({tag, ".rpc"}, redirect_pc, e.rpc);
  endtask

  // ---- reference model: an event is a list of CSR writes followed by a redirect
  function automatic logic [31:0] model_trap_ms(input logic [31:0] ms);
    logic [31:0] mie;
    mie = (ms >> 3) & 32'd1;
    return (ms & ~32'h88) | (mie << 7) | 32'h1800;
  endfunction

  function automatic logic [31:0] model_mret_ms(input logic [31:0] ms);
    logic [31:0] mpie;
    mpie = (ms >> 7) & 32'd1;
    return (ms & ~32'h88) | (mpie << 3) | 32'h80 | 32'h1800;
  endfunction

  function automatic void push_write(input logic [11:0] a, input logic [31:0] d);
    out_t e;
    e.we = 1'b1; e.addr = a; e.wdata = d; e.stall = 1'b1;
    e.flush = (exp_q.size() == 0); e.rv = 1'b0; e.rpc = '0;
    exp_q.push_back(e);
  endfunction

  function automatic void push_redirect(input logic [31:0] target);
    out_t e;
    e.we = 1'b0; e.addr = '0; e.wdata = '0; e.stall = 1'b1;
    e.flush = 1'b0; e.rv = 1'b1; e.rpc = target & ~32'd3;
    exp_q.push_back(e);
  endfunction

  function automatic void model_event();
    exp_q.delete();
    if (exc_valid) begin
      push_write(12'h341, pc_in & ~32'd3);
      push_write(12'h342, {28'b0, exc_cause});
      push_write(12'h343, exc_tval);
      push_write(12'h300, model_trap_ms(mstatus_in));
      push_redirect(mtvec_in);
    end else if (irq_ext && mie_meie && mstatus_in[3]) begin
      push_write(12'h341, pc_in & ~32'd3);
      push_write(12'h342, 32'h8000_000B);
      push_write(12'h343, 32'h0);
      push_write(12'h300, model_trap_ms(mstatus_in));
      push_redirect(mtvec_in);
    end else if (mret_valid) begin
      push_write(12'h300, model_mret_ms(mstatus_in));
      push_redirect(mepc_in);
    end
  endfunction

  task automatic quiet();
    exc_valid = 1'b0; mret_valid = 1'b0; irq_ext = 1'b0;
  endtask

  // Events presented while busy must be ignored and must not disturb captured data.
  task automatic noise();
    exc_valid  = 1'($urandom_range(0, 1));
    mret_valid = 1'($urandom_range(0, 1));
    irq_ext    = 1'($urandom_range(0, 1));
    exc_cause  = 4'($urandom);
    exc_tval   = $urandom;
    pc_in      = $urandom;
    mstatus_in = $urandom;
  endtask

  // Presents the currently driven event at the next edge and checks every cycle
  // up to and including the redirect; the next edge after return is IDLE.
  task automatic run(input string tag);
    model_event();
    @(posedge clk); #1;
    chk({tag, ".acc_stall"}, {31'b0, stall}, 32'd0);
    chk({tag, ".acc_we"}, {31'b0, csr_we}, 32'd0);
    quiet();
    if (exp_q.size() != 0) noise();
    foreach (exp_q[i]) begin
      @(posedge clk); #1;
      chk_out($sformatf("%s.c%0d", tag, i + 1), exp_q[i]);
      if (i == exp_q.size() - 1) quiet();
      else noise();
    end
  endtask

  task automatic set_event(input logic ev, input logic [3:0] c, input logic [31:0] pc,
                           input logic [31:0] tv, input logic [31:0] ms,
                           input logic mr, input logic irq);
    exc_valid = ev; exc_cause = c; pc_in = pc; exc_tval = tv;
    mstatus_in = ms; mret_valid = mr; irq_ext = irq;
  endtask

  initial begin
    exc_cause_e causes[6];
    causes = '{CAUSE_INSTR_MISALIGN, CAUSE_ILLEGAL, CAUSE_BREAKPOINT,
               CAUSE_LD_MISALIGN, CAUSE_ST_MISALIGN, CAUSE_ECALL_M};

    resetb = 1'b0;
    quiet();
    exc_cause = '0; exc_tval = '0; pc_in = '0; mie_meie = 1'b0;
    mstatus_in = '0; mtvec_in = '0; mepc_in = '0;
    #2;
    chk("rst.we", {31'b0, csr_we}, 32'd0);
    chk("rst.stall", {31'b0, stall}, 32'd0);
    chk("rst.rv", {31'b0, redirect_valid}, 32'd0);
    chk("rst.wdata", csr_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;

    // Illegal instruction
    mtvec_in = 32'h200; mepc_in = 32'h0;
    set_event(1'b1, CAUSE_ILLEGAL, 32'h100, 32'hDEAD_BEEF, 32'h8, 1'b0, 1'b0);
    run("illegal");
    chk("illegal.mstatus_lit", exp_q[3].wdata, 32'h1880);

    // External interrupt enabled
    mie_meie = 1'b1; mtvec_in = 32'h0000_0803;
    set_event(1'b0, 4'd0, 32'h44, 32'h0, 32'h8, 1'b0, 1'b1);
    run("irq");

    // Interrupt with MIE clear: no response
    set_event(1'b0, 4'd0, 32'h44, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("irq_mie0.stall%0d", i), {31'b0, stall}, 32'd0);
      chk($sformatf("irq_mie0.we%0d", i), {31'b0, csr_we}, 32'd0);
    end
    quiet();

    // MRET
    mepc_in = 32'h104;
    set_event(1'b0, 4'd0, 32'h0, 32'h0, 32'h1880, 1'b1, 1'b0);
    run("mret");

    // Simultaneous exception, MRET and interrupt, then MRET accepted at T+6
    mtvec_in = 32'h300; mepc_in = 32'h2000;
    set_event(1'b1, CAUSE_ECALL_M, 32'h58, 32'h0, 32'h8, 1'b1, 1'b1);
    run("simul");
    set_event(1'b0, 4'd0, 32'h0, 32'h0, 32'h80, 1'b1, 1'b0);
    run("mret_t6");

    // Reset while in SAVE_CAUSE
    set_event(1'b1, CAUSE_ECALL_M, 32'h600, 32'h0, 32'h8, 1'b0, 1'b0);
    @(posedge clk); #1;
    quiet();
    @(posedge clk); #1;
    chk("rst_mid.pre_we", {31'b0, csr_we}, 32'd1);
    resetb = 1'b0;
    #1;
    chk("rst_mid.we", {31'b0, csr_we}, 32'd0);
    chk("rst_mid.addr", {20'b0, csr_addr}, 32'd0);
    chk("rst_mid.stall", {31'b0, stall}, 32'd0);
    chk("rst_mid.flush", {31'b0, flush}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_mid.rv%0d", i), {31'b0, redirect_valid}, 32'd0);
      chk($sformatf("rst_mid.held_we%0d", i), {31'b0, csr_we}, 32'd0);
    end
    resetb = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid.post_rv", {31'b0, redirect_valid}, 32'd0);
    set_event(1'b1, CAUSE_ECALL_M, 32'h700, 32'h0, 32'h8, 1'b0, 1'b0);
    run("ecall_after_rst");

    // Randomized back-to-back events
    for (int n = 0; n < 40; n++) begin
      mtvec_in = $urandom;
      mepc_in  = $urandom;
      mie_meie = 1'($urandom_range(0, 1));
      set_event(1'($urandom_range(0, 2) == 0), causes[$urandom_range(0, 5)],
                $urandom, $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run($sformatf("rnd%0d", n));
    end

    @(posedge clk); #1;
    chk("final.stall", {31'b0, stall}, 32'd0);
    chk("final.rv", {31'b0, redirect_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 The block SHALL have these ports (name direction width meaning), with reset resetb asynchronous active-low and clock clk:
- clk  in  1  clock
- resetb  in  1  async active-low reset
- exc_valid  in  1  commit-stage instruction raised a synchronous exception
- exc_cause  in  4  exception code (0 instr-misaligned, 2 illegal, 3 ebreak, 4/6 ld/st-misaligned, 11 ecall)
- exc_tval  in  32  faulting address/instruction
- pc_in  in  32  PC of commit-stage instruction
- mret_valid  in  1  commit-stage instruction is MRET
- irq_ext  in  1  external interrupt pending
- mie_meie  in  1  mie.MEIE
- mstatus_in  in  32  current mstatus
- mtvec_in  in  32  current mtvec
- mepc_in  in  32  current mepc
- csr_we  out  1  CSR write strobe to csrrf
- csr_addr  out  12  CSR write address
- csr_wdata  out  32  CSR write data
- stall  out  1  freeze pipeline
- flush  out  1  kill in-flight instructions
- redirect_valid  out  1  fetch redirect strobe
- redirect_pc  out  32  redirect target

Function
REQ-002 FSM states SHALL be IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, SAVE_STATUS, MRET_STATUS, REDIRECT; all outputs SHALL be registered and decoded from state.
REQ-003 In IDLE, priority SHALL be exc_valid > interrupt (irq_ext & mie_meie & mstatus_in[3]) > mret_valid; only one event is accepted per edge.
REQ-004 On acceptance, pc_in, cause, tval, mstatus_in SHALL be latched; later input changes do not affect the sequence.
REQ-005 Exception/interrupt path SHALL be IDLE->SAVE_EPC->SAVE_CAUSE->SAVE_TVAL->SAVE_STATUS->REDIRECT->IDLE, one CSR write per state.
REQ-006 SAVE_EPC: csr_addr 0x341, wdata = latched pc with bits[1:0] cleared.
REQ-007 SAVE_CAUSE: addr 0x342, wdata = {28'b0,exc_cause} for exceptions, 32'h8000000B for interrupt.
REQ-008 SAVE_TVAL: addr 0x343, wdata = latched exc_tval for exceptions, 0 for interrupt.
REQ-009 SAVE_STATUS: addr 0x300, wdata = latched mstatus with MPIE(bit7)=MIE(bit3), MIE=0, MPP(12:11)=2'b11.
REQ-010 MRET path SHALL be IDLE->MRET_STATUS->REDIRECT->IDLE; MRET_STATUS writes 0x300 with MIE=MPIE, MPIE=1, MPP=2'b11.
REQ-011 REDIRECT: redirect_valid=1, csr_we=0; redirect_pc = {mtvec_in[31:2],2'b00} for trap (direct mode only), {mepc_in[31:2],2'b00} for MRET, sampled in REDIRECT.
REQ-012 stall SHALL be 1 in every non-IDLE state; flush SHALL be 1 only in SAVE_EPC or MRET_STATUS.
REQ-013 csr_we SHALL be 1 exactly in SAVE_* and MRET_STATUS states; csr_addr/csr_wdata SHALL be 0 when csr_we=0.
REQ-014 Trap latency: acceptance edge T -> redirect_valid at T+5; MRET: redirect_valid at T+2; next event accepted at T+6 / T+3.
REQ-015 Events arriving while not IDLE SHALL be ignored (not queued); irq_ext still asserted is re-evaluated in IDLE.
REQ-016 Simultaneous exc_valid and mret_valid SHALL take the exception path (MRET faulting).

Reset
REQ-017 On resetb low, state SHALL be IDLE and all outputs 0 asynchronously; latched fields 0.
REQ-018 Reset mid-sequence SHALL abandon the sequence with no further CSR write or redirect.

Structure
REQ-019 CSR addresses (shared with csrrf), cause codes and mstatus bit positions SHALL live in the shared CSR definitions package/header; state encoding stays local.
REQ-020 No sub-module; single FSM plus capture registers.

Verification
REQ-021 Illegal instr: exc_valid, cause 2, pc 0x100, tval 0xDEADBEEF, mstatus 0x8, mtvec 0x200 -> writes 341=0x100, 342=2, 343=0xDEADBEEF, 300=0x1880; redirect 0x200 at T+5.
REQ-022 Interrupt: irq_ext, meie=1, MIE=1, pc 0x44 -> 342=0x8000000B, 343=0, redirect mtvec; with MIE=0 -> no response, stall stays 0.
REQ-023 MRET: mstatus 0x1880, mepc 0x104 -> 300=0x1888, redirect 0x104 at T+2, flush at T+1 only.
REQ-024 exc_valid+mret_valid+irq_ext same cycle -> exception sequence only; mret re-presented after T+6 is accepted.
REQ-025 resetb low during SAVE_CAUSE -> all outputs 0 immediately, no redirect; after release, new ecall completes normally.
